// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one external memory bus between the instruction-fetch requester (IF)
// and the data-access requester (MEM). One bus transaction is in flight at a
// time; data accesses win over fetches when both are waiting in IDLE. A
// per-transaction timeout terminates a transfer to a slave that never acks.
//
// State table
//   IDLE | no bus transaction; arbitrate between mem and fetch requests
//   DATA | data access on the bus, waiting for bus_ack_i or timeout
//   INST | instruction fetch on the bus, waiting for bus_ack_i or timeout
//   DROP | flushed fetch still on the bus; result and ack are discarded
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   if_req_i/if_addr_i    fetch request and word address
//   if_rdata_o/if_ack_o   fetched word, one-cycle completion pulse
//   flush_i               discards an in-flight or newly presented fetch
//   mem_req_i/we/sel/addr/wdata   data access request
//   mem_rdata_o/mem_ack_o load data, one-cycle completion pulse
//   bus_*_o               registered bus master outputs
//   bus_rdata_i/bus_ack_i slave response, meaningful while bus_cyc_o is high
//   stallreq_if_o/stallreq_mem_o  combinational stall requests
//   err_o                 one-cycle pulse when a transaction times out

module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_ack_o,
    input  logic        flush_i,

    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_ack_o,

    output logic        bus_cyc_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,

    output logic        stallreq_if_o,
    output logic        stallreq_mem_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        INST = 2'd2,
        DROP = 2'd3
    } state_t;

    // Counter value on the last cycle a transaction may still be acked.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  cnt;
    logic [7:0]  cnt_nxt;

    logic        bus_cyc_nxt;
    logic        bus_we_nxt;
    logic [3:0]  bus_sel_nxt;
    logic [31:0] bus_addr_nxt;
    logic [31:0] bus_wdata_nxt;
    logic [31:0] if_rdata_nxt;
    logic [31:0] mem_rdata_nxt;
    logic        if_ack_nxt;
    logic        mem_ack_nxt;
    logic        err_nxt;

    logic        timed_out;
    logic        fetch_live;

    // An ack in the same cycle as the terminal count wins over the timeout.
    assign timed_out = ~bus_ack_i & (cnt == CNT_LAST);

    // A fetch flushed in the cycle it completes is treated as discarded.
    assign fetch_live = (state == INST) & ~flush_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            bus_cyc_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= 4'd0;
            bus_addr_o  <= 32'd0;
            bus_wdata_o <= 32'd0;
            if_rdata_o  <= 32'd0;
            mem_rdata_o <= 32'd0;
            if_ack_o    <= 1'b0;
            mem_ack_o   <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            bus_cyc_o   <= bus_cyc_nxt;
            bus_we_o    <= bus_we_nxt;
            bus_sel_o   <= bus_sel_nxt;
            bus_addr_o  <= bus_addr_nxt;
            bus_wdata_o <= bus_wdata_nxt;
            if_rdata_o  <= if_rdata_nxt;
            mem_rdata_o <= mem_rdata_nxt;
            if_ack_o    <= if_ack_nxt;
            mem_ack_o   <= mem_ack_nxt;
            err_o       <= err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        bus_cyc_nxt   = bus_cyc_o;
        bus_we_nxt    = bus_we_o;
        bus_sel_nxt   = bus_sel_o;
        bus_addr_nxt  = bus_addr_o;
        bus_wdata_nxt = bus_wdata_o;
        if_rdata_nxt  = if_rdata_o;
        mem_rdata_nxt = mem_rdata_o;
        if_ack_nxt    = 1'b0;
        mem_ack_nxt   = 1'b0;
        err_nxt       = 1'b0;

        case (state)
            IDLE: begin
                if (mem_req_i) begin
                    state_nxt     = DATA;
                    cnt_nxt       = 8'd0;
                    bus_cyc_nxt   = 1'b1;
                    bus_we_nxt    = mem_we_i;
                    bus_sel_nxt   = mem_sel_i;
                    bus_addr_nxt  = mem_addr_i;
                    bus_wdata_nxt = mem_wdata_i;
                end else if (if_req_i && !flush_i) begin
                    state_nxt     = INST;
                    cnt_nxt       = 8'd0;
                    bus_cyc_nxt   = 1'b1;
                    bus_we_nxt    = 1'b0;
                    bus_sel_nxt   = 4'b1111;
                    bus_addr_nxt  = if_addr_i;
                end
            end

            DATA, INST, DROP: begin
                if (bus_ack_i) begin
                    state_nxt   = IDLE;
                    bus_cyc_nxt = 1'b0;
                    if (state == DATA) begin
                        mem_ack_nxt = 1'b1;
                        // Stores leave the load data register untouched.
                        if (!bus_we_o) begin
                            mem_rdata_nxt = bus_rdata_i;
                        end
                    end else if (fetch_live) begin
                        if_ack_nxt   = 1'b1;
                        if_rdata_nxt = bus_rdata_i;
                    end
                end else if (timed_out) begin
                    state_nxt   = IDLE;
                    bus_cyc_nxt = 1'b0;
                    err_nxt     = 1'b1;
                    if (state == DATA) begin
                        mem_ack_nxt   = 1'b1;
                        mem_rdata_nxt = ERR_DATA;
                    end else if (fetch_live) begin
                        if_ack_nxt   = 1'b1;
                        if_rdata_nxt = ERR_DATA;
                    end
                end else begin
                    cnt_nxt = cnt + 8'd1;
                    // The bus cannot be aborted, so a flushed fetch keeps
                    // running and only its result is thrown away.
                    if (state == INST && flush_i) begin
                        state_nxt = DROP;
                    end
                end
            end

            default: begin
                state_nxt   = IDLE;
                bus_cyc_nxt = 1'b0;
            end
        endcase
    end

    assign stallreq_mem_o = mem_req_i & ~mem_ack_o;
    assign stallreq_if_o  = if_req_i & ~if_ack_o;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: stimulus plans each transaction and
// queues the expected bus cycle and requester response; a slave process
// answers the bus with planned latencies; a monitor pops and compares.

module tb_mem_bus_arbiter;

    localparam int          TO  = 4;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_ack_o;
    logic        flush_i;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_rdata_o;
    logic        mem_ack_o;
    logic        bus_cyc_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;
    logic        stallreq_if_o;
    logic        stallreq_mem_o;
    logic        err_o;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i),
        .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o), .flush_i(flush_i),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .mem_rdata_o(mem_rdata_o), .mem_ack_o(mem_ack_o),
        .bus_cyc_o(bus_cyc_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
        .stallreq_if_o(stallreq_if_o), .stallreq_mem_o(stallreq_mem_o),
        .err_o(err_o)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic        chk_wdata;
        int          len;
    } bus_exp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } ack_exp_t;

    bus_exp_t    bus_q[$];
    ack_exp_t    if_q[$];
    ack_exp_t    mem_q[$];
    int          slv_lat_q[$];
    logic [31:0] slv_data_q[$];

    logic [31:0] if_last  = 32'd0;
    logic [31:0] mem_last = 32'd0;
    int          exp_err  = 0;
    int          err_seen = 0;
    int          checks   = 0;
    int          passes   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic int eff(input int lat);
        return (lat == 0) ? TO : lat;
    endfunction

    // Reference model: a transaction occupies the bus for its latency (or the
    // full timeout), reads return slave data, writes leave rdata alone, a
    // timeout returns ERR with err, a discarded fetch returns nothing.
    task automatic plan(input bit inst, input bit we, input logic [3:0] sel,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int lat, input logic [31:0] data, input bit discard);
        bus_exp_t b;
        ack_exp_t a;
        b.addr      = addr;
        b.we        = inst ? 1'b0 : we;
        b.sel       = inst ? 4'b1111 : sel;
        b.wdata     = wdata;
        b.chk_wdata = !inst;
        b.len       = eff(lat);
        bus_q.push_back(b);
        slv_lat_q.push_back(lat);
        slv_data_q.push_back(data);
        if (lat == 0) exp_err++;
        if (!discard) begin
            a.err = (lat == 0);
            if (lat == 0) a.rdata = ERR;
            else if (!inst && we) a.rdata = mem_last;
            else a.rdata = data;
            if (inst) begin
                if_q.push_back(a);
                if_last = a.rdata;
            end else begin
                mem_q.push_back(a);
                mem_last = a.rdata;
            end
        end
    endtask

    // Slave: acks on the planned cycle of each bus transaction, never for lat 0.
    initial begin
        int s_lat;
        int s_n;
        logic [31:0] s_data;
        logic s_prev;
        s_lat = 1; s_n = 0; s_data = 32'd0; s_prev = 1'b0;
        bus_ack_i = 1'b0;
        bus_rdata_i = 32'd0;
        forever begin
            @(negedge clk);
            if (bus_cyc_o === 1'b1) begin
                if (!s_prev) begin
                    if (slv_lat_q.size() > 0) begin
                        s_lat  = slv_lat_q.pop_front();
                        s_data = slv_data_q.pop_front();
                    end else begin
                        s_lat = 1; s_data = 32'd0;
                    end
                    s_n = 1;
                end else begin
                    s_n++;
                end
                bus_ack_i   = (s_lat != 0) && (s_n == s_lat);
                bus_rdata_i = bus_ack_i ? s_data : $urandom();
            end else begin
                bus_ack_i = 1'b0;
            end
            s_prev = (bus_cyc_o === 1'b1);
        end
    end

    // Monitor
    initial begin
        logic m_prev;
        int m_len;
        int m_len_exp;
        bus_exp_t e;
        ack_exp_t a;
        m_prev = 1'b0; m_len = 0; m_len_exp = 0;
        forever begin
            @(negedge clk);
            #2;
            chk("stallreq_if", {31'd0, stallreq_if_o}, {31'd0, if_req_i & ~if_ack_o});
            chk("stallreq_mem", {31'd0, stallreq_mem_o}, {31'd0, mem_req_i & ~mem_ack_o});
            if (bus_cyc_o && !m_prev) begin
                if (bus_q.size() == 0) begin
                    checks++;
                    $display("FAIL bus_grant: unexpected bus cycle addr %h, none expected", bus_addr_o);
                    m_len_exp = -1;
                end else begin
                    e = bus_q.pop_front();
                    chk("bus_addr", bus_addr_o, e.addr);
                    chk("bus_we", {31'd0, bus_we_o}, {31'd0, e.we});
                    chk("bus_sel", {28'd0, bus_sel_o}, {28'd0, e.sel});
                    if (e.chk_wdata) chk("bus_wdata", bus_wdata_o, e.wdata);
                    m_len_exp = e.len;
                end
                m_len = 0;
            end
            if (bus_cyc_o) m_len++;
            if (!bus_cyc_o && m_prev && m_len_exp >= 0)
                chk("bus_cyc_len", 32'(m_len), 32'(m_len_exp));
            if (if_ack_o) begin
                if (if_q.size() == 0) begin
                    checks++;
                    $display("FAIL if_ack: unexpected ack rdata %h, none expected", if_rdata_o);
                end else begin
                    a = if_q.pop_front();
                    chk("if_rdata", if_rdata_o, a.rdata);
                    chk("if_err", {31'd0, err_o}, {31'd0, a.err});
                end
            end
            if (mem_ack_o) begin
                if (mem_q.size() == 0) begin
                    checks++;
                    $display("FAIL mem_ack: unexpected ack rdata %h, none expected", mem_rdata_o);
                end else begin
                    a = mem_q.pop_front();
                    chk("mem_rdata", mem_rdata_o, a.rdata);
                    chk("mem_err", {31'd0, err_o}, {31'd0, a.err});
                end
            end
            if (err_o) err_seen++;
            m_prev = bus_cyc_o;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (bus_cyc_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            $display("FAIL idle_wait: bus_cyc_o still high after %0d cycles", n);
        end
        repeat (2) @(negedge clk);
    endtask

    // Called at the negedge requests were raised (cycle 0); returns the
    // cycle number each ack was seen, dropping the request on its ack.
    task automatic wait_acks(input bit want_if, input bit want_mem,
                             output int if_cyc, output int mem_cyc);
        int n = 0;
        bit if_done = !want_if;
        bit mem_done = !want_mem;
        if_cyc = -1; mem_cyc = -1;
        while (!(if_done && mem_done) && n < 4 * TO + 20) begin
            @(negedge clk);
            n++;
            if (mem_ack_o && !mem_done) begin mem_req_i = 1'b0; mem_done = 1'b1; mem_cyc = n; end
            if (if_ack_o && !if_done) begin if_req_i = 1'b0; if_done = 1'b1; if_cyc = n; end
        end
        if (!(if_done && mem_done)) begin
            checks++;
            $display("FAIL ack_wait: no ack after %0d cycles (if %0d mem %0d)", n, if_done, mem_done);
            if_req_i = 1'b0; mem_req_i = 1'b0;
        end
    endtask

    task automatic single(input int kind, input logic [31:0] addr, input logic [3:0] sel,
                          input logic [31:0] wdata, input int lat, input logic [31:0] data);
        int ic, mc;
        if (kind == 0) begin
            plan(1'b1, 1'b0, 4'hF, addr, 32'd0, lat, data, 1'b0);
            if_addr_i = addr; if_req_i = 1'b1;
            wait_acks(1'b1, 1'b0, ic, mc);
            chk("if_latency", 32'(ic), 32'(eff(lat) + 1));
        end else begin
            plan(1'b0, kind == 2, sel, addr, wdata, lat, data, 1'b0);
            mem_addr_i = addr; mem_sel_i = sel; mem_wdata_i = wdata;
            mem_we_i = (kind == 2); mem_req_i = 1'b1;
            wait_acks(1'b0, 1'b1, ic, mc);
            chk("mem_latency", 32'(mc), 32'(eff(lat) + 1));
        end
        wait_idle();
    endtask

    task automatic contend(input bit we, input logic [3:0] sel, input logic [31:0] maddr,
                           input logic [31:0] wdata, input int mlat, input logic [31:0] mdata,
                           input logic [31:0] iaddr, input int ilat, input logic [31:0] idata);
        int ic, mc;
        plan(1'b0, we, sel, maddr, wdata, mlat, mdata, 1'b0);
        plan(1'b1, 1'b0, 4'hF, iaddr, 32'd0, ilat, idata, 1'b0);
        mem_addr_i = maddr; mem_sel_i = sel; mem_wdata_i = wdata; mem_we_i = we;
        if_addr_i = iaddr;
        mem_req_i = 1'b1; if_req_i = 1'b1;
        wait_acks(1'b1, 1'b1, ic, mc);
        chk("contend_mem_latency", 32'(mc), 32'(eff(mlat) + 1));
        chk("contend_if_latency", 32'(ic), 32'(eff(mlat) + 2 + eff(ilat)));
        wait_idle();
    endtask

    task automatic flush_fetch(input logic [31:0] addr, input int lat, input logic [31:0] data,
                               input int j);
        int n = 0;
        plan(1'b1, 1'b0, 4'hF, addr, 32'd0, lat, data, 1'b1);
        if_addr_i = addr; if_req_i = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_cyc_o && n < 20);
        if (!bus_cyc_o) begin
            checks++;
            $display("FAIL flush_grant: fetch never granted");
        end
        for (int c = 1; c < j; c++) @(negedge clk);
        flush_i = 1'b1; if_req_i = 1'b0;
        @(negedge clk);
        flush_i = 1'b0;
        wait_idle();
        chk("flush_if_rdata_kept", if_rdata_o, if_last);
    endtask

    task automatic idle_flush(input logic [31:0] addr);
        if_addr_i = addr; if_req_i = 1'b1; flush_i = 1'b1;
        @(negedge clk);
        if_req_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        chk("flush_idle_no_grant", {31'd0, bus_cyc_o}, 32'd0);
        wait_idle();
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_bus_cyc"}, {31'd0, bus_cyc_o}, 32'd0);
        chk({tag, "_bus_we"}, {31'd0, bus_we_o}, 32'd0);
        chk({tag, "_bus_sel"}, {28'd0, bus_sel_o}, 32'd0);
        chk({tag, "_bus_addr"}, bus_addr_o, 32'd0);
        chk({tag, "_bus_wdata"}, bus_wdata_o, 32'd0);
        chk({tag, "_if_rdata"}, if_rdata_o, 32'd0);
        chk({tag, "_mem_rdata"}, mem_rdata_o, 32'd0);
        chk({tag, "_acks_err"}, {29'd0, if_ack_o, mem_ack_o, err_o}, 32'd0);
    endtask

    initial begin
        int kind, lat, j, n;
        bus_exp_t b;
        rst = 1'b1;
        if_req_i = 1'b0; if_addr_i = 32'd0; flush_i = 1'b0;
        mem_req_i = 1'b0; mem_we_i = 1'b0; mem_sel_i = 4'd0;
        mem_addr_i = 32'd0; mem_wdata_i = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_state("reset");
        @(negedge clk);

        single(0, 32'h0000_0100, 4'hF, 32'd0, 1, 32'h3C01_1234);
        contend(1'b1, 4'b0011, 32'h0000_0080, 32'h0000_ABCD, 1, 32'h1111_2222,
                32'h0000_0104, 1, 32'h2000_0001);
        flush_fetch(32'h0000_0108, 4, 32'h5555_AAAA, 2);
        single(1, 32'h0000_0200, 4'hF, 32'd0, 0, 32'h7777_7777);
        single(1, 32'h0000_0204, 4'hF, 32'd0, TO, 32'h0BAD_F00D);
        single(2, 32'h0000_0208, 4'b1100, 32'h1234_5678, 2, 32'h9999_9999);

        // Reset in the middle of a load to a silent slave.
        b.addr = 32'h0000_0300; b.we = 1'b0; b.sel = 4'hF; b.wdata = 32'd0;
        b.chk_wdata = 1'b1; b.len = 2;
        bus_q.push_back(b);
        slv_lat_q.push_back(0);
        slv_data_q.push_back(32'd0);
        mem_addr_i = 32'h0000_0300; mem_sel_i = 4'hF; mem_wdata_i = 32'd0;
        mem_we_i = 1'b0; mem_req_i = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_cyc_o && n < 20);
        @(negedge clk);
        rst = 1'b1; mem_req_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mem_last = 32'd0; if_last = 32'd0;
        check_reset_state("midreset");
        repeat (TO + 2) @(negedge clk);
        chk("midreset_no_ack", {30'd0, if_ack_o, mem_ack_o}, 32'd0);
        single(1, 32'h0000_0304, 4'hF, 32'd0, 3, 32'hC0DE_0001);

        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 5);
            lat  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TO);
            case (kind)
                0, 1, 2: single(kind, $urandom(), 4'($urandom_range(1, 15)), $urandom(), lat, $urandom());
                3: contend($urandom_range(0, 1) == 1, 4'($urandom_range(1, 15)), $urandom(), $urandom(),
                           lat, $urandom(), $urandom(), $urandom_range(1, TO), $urandom());
                4: begin
                    j = (lat == 0) ? $urandom_range(1, TO - 1) : $urandom_range(1, lat);
                    flush_fetch($urandom(), lat, $urandom(), j);
                end
                default: idle_flush($urandom());
            endcase
        end

        #3;
        chk("err_pulses", 32'(err_seen), 32'(exp_err));
        chk("queues_drained", 32'(if_q.size() + mem_q.size() + bus_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
